// File: rtl/key_conditioner.sv
// Pushbutton and switch conditioner: two independent debounced key channels
// (level + one-cycle press strobe) and a plain two-flop synchronizer for S.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] S,
    output logic        Run_db,
    output logic        Continue_db,
    output logic        Run_pulse,
    output logic        Continue_pulse,
    output logic [15:0] S_sync,
    output logic [1:0]  run_state_o,
    output logic [1:0]  continue_state_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [1:0]  key_raw;
    logic [1:0]  db_w;
    logic [1:0]  pulse_w;
    logic [3:0]  state_w;
    logic [15:0] s_meta_q;
    logic [15:0] s_sync_q;

    assign key_raw = {Continue, Run};

    // Channel 0 is Run, channel 1 is Continue; each has its own synchronizer,
    // counter and FSM so the two keys never interact.
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic          sync1_q;
        logic          sync2_q;
        logic          db_q;
        logic          pulse_q;
        logic [CW-1:0] cnt_q;
        state_t        state_q;

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                state_q <= IDLE;
                cnt_q   <= '0;
                db_q    <= 1'b1;
                pulse_q <= 1'b0;
            end else begin
                sync1_q <= key_raw[c];
                sync2_q <= sync1_q;
                pulse_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (!sync2_q) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (sync2_q) begin
                            state_q <= IDLE;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q <= PRESSED;
                            pulse_q <= 1'b1;
                            db_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (sync2_q) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        // Bouncing back low resumes the held press without a new strobe.
                        if (!sync2_q) begin
                            state_q <= PRESSED;
                        end else if (cnt_q == CNT_MAX) begin
                            state_q <= IDLE;
                            db_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign db_w[c]             = db_q;
        assign pulse_w[c]          = pulse_q;
        assign state_w[2*c +: 2]   = state_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s_meta_q <= '0;
            s_sync_q <= '0;
        end else begin
            s_meta_q <= S;
            s_sync_q <= s_meta_q;
        end
    end

    assign Run_db           = db_w[0];
    assign Continue_db      = db_w[1];
    assign Run_pulse        = pulse_w[0];
    assign Continue_pulse   = pulse_w[1];
    assign S_sync           = s_sync_q;
    assign run_state_o      = state_w[1:0];
    assign continue_state_o = state_w[3:2];

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4: directed
// scenarios followed by randomized key/switch/reset activity.
module tb_key_conditioner;

    localparam int D = 4;
    localparam int W = 20;

    logic        Clk      = 1'b0;
    logic        Reset    = 1'b0;
    logic        Run      = 1'b1;
    logic        Continue = 1'b1;
    logic [15:0] S        = '0;
    logic        Run_db;
    logic        Continue_db;
    logic        Run_pulse;
    logic        Continue_pulse;
    logic [15:0] S_sync;
    logic [1:0]  run_state;
    logic [1:0]  continue_state;

    key_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Run              (Run),
        .Continue         (Continue),
        .S                (S),
        .Run_db           (Run_db),
        .Continue_db      (Continue_db),
        .Run_pulse        (Run_pulse),
        .Continue_pulse   (Continue_pulse),
        .S_sync           (S_sync),
        .run_state_o      (run_state),
        .continue_state_o (continue_state)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    int run_pulses = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    // A key's accepted level flips once the synchronized key (raw delayed two
    // edges) has disagreed with it on D+1 consecutive edges.
    logic        m_run_lvl, m_cont_lvl;
    int          m_run_cnt, m_cont_cnt;
    logic        m_run_hist[$];
    logic        m_cont_hist[$];
    logic [15:0] m_s_hist[$];

    function automatic void model_reset();
        m_run_lvl   = 1'b1;
        m_cont_lvl  = 1'b1;
        m_run_cnt   = 0;
        m_cont_cnt  = 0;
        m_run_hist  = '{1'b1, 1'b1};
        m_cont_hist = '{1'b1, 1'b1};
        m_s_hist    = '{16'h0000, 16'h0000};
    endfunction

    function automatic void debounce(input logic sv, inout logic lvl, inout int cnt,
                                     output logic pulse);
        pulse = 1'b0;
        if (sv != lvl) begin
            cnt++;
            if (cnt == D + 1) begin
                pulse = lvl;
                lvl   = ~lvl;
                cnt   = 0;
            end
        end else begin
            cnt = 0;
        end
    endfunction

    task automatic model_edge();
        logic sv_r, sv_c, p_r, p_c;
        logic [15:0] s_exp;
        if (!Reset) begin
            model_reset();
            exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
        end else begin
            sv_r = m_run_hist.pop_front();
            m_run_hist.push_back(Run);
            sv_c = m_cont_hist.pop_front();
            m_cont_hist.push_back(Continue);
            debounce(sv_r, m_run_lvl, m_run_cnt, p_r);
            debounce(sv_c, m_cont_lvl, m_cont_cnt, p_c);
            m_s_hist.push_back(S);
            s_exp = m_s_hist[m_s_hist.size() - 2];
            while (m_s_hist.size() > 2) void'(m_s_hist.pop_front());
            exp_q.push_back({m_run_lvl, m_cont_lvl, p_r, p_c, s_exp});
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic run, input logic cont,
                        input logic [15:0] s);
        logic [W-1:0] got;
        @(negedge Clk);
        #1;
        Reset    = rst;
        Run      = run;
        Continue = cont;
        S        = s;
        if (!rst) begin
            #1;
            got = {Run_db, Continue_db, Run_pulse, Continue_pulse, S_sync};
            checks++;
            if (got !== {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
                errors++;
                $display("FAIL reset_immediate t=%0t got=%h required=%h", $time, got,
                         {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
            end
        end
        @(posedge Clk);
        cycle_no++;
        model_edge();
    endtask

    task automatic hold(input int n, input logic rst, input logic run, input logic cont,
                        input logic [15:0] s);
        for (int i = 0; i < n; i++) step(rst, run, cont, s);
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        logic [W-1:0] exp_v, got_v;
        if (Run_pulse) run_pulses++;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {Run_db, Continue_db, Run_pulse, Continue_pulse, S_sync};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL outputs cycle=%0d got db=%b%b pulse=%b%b s=%h required db=%b%b pulse=%b%b s=%h",
                         cycle_no, got_v[19], got_v[18], got_v[17], got_v[16], got_v[15:0],
                         exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        logic r, c, rst;
        logic [15:0] s;

        model_reset();

        // Reset with switches already set, then release.
        hold(3, 1'b0, 1'b1, 1'b1, 16'h0014);
        hold(4, 1'b1, 1'b1, 1'b1, 16'h0014);

        // Long Run press and release; exactly one strobe expected.
        p0 = run_pulses;
        hold(20, 1'b1, 1'b0, 1'b1, 16'h0014);
        hold(12, 1'b1, 1'b1, 1'b1, 16'h0014);
        @(negedge Clk);
        checks++;
        if (run_pulses - p0 != 1) begin
            errors++;
            $display("FAIL run_pulse_count got=%0d required=1", run_pulses - p0);
        end

        // Short Continue glitches rejected.
        hold(3, 1'b1, 1'b1, 1'b0, 16'h0014);
        hold(1, 1'b1, 1'b1, 1'b1, 16'h0014);
        hold(3, 1'b1, 1'b1, 1'b0, 16'h0014);
        hold(10, 1'b1, 1'b1, 1'b1, 16'h0014);

        // Simultaneous presses.
        hold(10, 1'b1, 1'b0, 1'b0, 16'h0014);
        hold(10, 1'b1, 1'b1, 1'b1, 16'h0014);

        // Reset mid-debounce with Run held low through release.
        hold(3, 1'b1, 1'b0, 1'b1, 16'h0014);
        hold(2, 1'b0, 1'b0, 1'b1, 16'h0014);
        hold(12, 1'b1, 1'b0, 1'b1, 16'h0014);
        hold(10, 1'b1, 1'b1, 1'b1, 16'h0014);

        // Reset right on a strobe cycle.
        hold(6, 1'b1, 1'b0, 1'b0, 16'h0014);
        hold(2, 1'b0, 1'b0, 1'b0, 16'h0014);
        hold(10, 1'b1, 1'b1, 1'b1, 16'h0014);

        // Switch synchronizer.
        hold(4, 1'b1, 1'b1, 1'b1, 16'h0055);
        hold(4, 1'b1, 1'b1, 1'b1, 16'h007F);

        // Random phase: toggle probability chosen so hold times straddle D+1.
        r = 1'b1;
        c = 1'b1;
        s = 16'h007F;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) r = ~r;
            if ($urandom_range(0, 3) == 0) c = ~c;
            if ($urandom_range(0, 2) == 0) s = 16'($urandom_range(0, 65535));
            rst = ($urandom_range(0, 80) == 0) ? 1'b0 : 1'b1;
            step(rst, r, c, s);
        end
        hold(12, 1'b1, 1'b1, 1'b1, s);

        @(negedge Clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
